// File: rtl/fish_game_pkg.sv
// fish_game_pkg: state encoding and per-level geometry
// tables shared by the fishing game engine.
package fish_game_pkg;

    typedef enum logic [1:0] {
        ST_FISH  = 2'd0,
        ST_CATCH = 2'd1,
        ST_WIN   = 2'd2
    } game_state_e;

    typedef struct packed {
        logic [5:0] half_h;
        logic [6:0] len;
        logic [6:0] hook_w;
        logic [9:0] lane_y;
    } level_geom_t;

    function automatic logic [5:0] size_half_h(
        input logic [2:0] lvl
    );
        logic [5:0] h;
        case (lvl)
            3'd0:    h = 6'd10;
            3'd1:    h = 6'd8;
            3'd2:    h = 6'd5;
            3'd3:    h = 6'd3;
            3'd4:    h = 6'd3;
            default: h = 6'd2;
        endcase
        return h;
    endfunction

    function automatic logic [6:0] size_len(
        input logic [2:0] lvl
    );
        logic [6:0] l;
        case (lvl)
            3'd0:    l = 7'd60;
            3'd1:    l = 7'd40;
            3'd2:    l = 7'd20;
            3'd3:    l = 7'd10;
            3'd4:    l = 7'd10;
            3'd5:    l = 7'd8;
            3'd6:    l = 7'd8;
            default: l = 7'd6;
        endcase
        return l;
    endfunction

    function automatic logic [6:0] hook_w(
        input logic [6:0] len
    );
        logic [6:0] q;
        q = len >> 2;
        return (q < 7'd2) ? 7'd2 : q;
    endfunction

    function automatic logic [9:0] lane_y(
        input int lvl,
        input int y0,
        input int step
    );
        return 10'(y0 - lvl * step);
    endfunction

endpackage

// File: rtl/fish_level_rom.sv
// fish_level_rom: level index to fish size, hook window
// and lane height; also the lane of the following level.
module fish_level_rom
    import fish_game_pkg::*;
#(
    parameter int NUM_LEVELS = 4,
    parameter int LANE_Y0    = 470,
    parameter int LANE_STEP  = 90
) (
    input  logic [2:0]  level,
    output level_geom_t geom,
    output logic [9:0]  next_lane_y
);

    logic [9:0] lane_tab [NUM_LEVELS];

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_lane
        assign lane_tab[g] = lane_y(g, LANE_Y0, LANE_STEP);
    end

    always_comb begin
        geom.half_h = size_half_h(level);
        geom.len    = size_len(level);
        geom.hook_w = hook_w(size_len(level));
        geom.lane_y = lane_tab[0];
        next_lane_y = lane_tab[0];
        for (int i = 1; i < NUM_LEVELS; i++) begin
            if (level == 3'(i))
                geom.lane_y = lane_tab[i];
            if (level == 3'(i - 1))
                next_lane_y = lane_tab[i];
        end
    end

endmodule

// File: rtl/fish_game_ctrl.sv
// fish_game_ctrl: frame-strobed game engine for the VGA
// fishing demo; exports rod, line and fish geometry.
module fish_game_ctrl
    import fish_game_pkg::*;
#(
    parameter int NUM_LEVELS = 4,
    parameter int H_MIN      = 312,
    parameter int H_MAX      = 798,
    parameter int ROD_X_RST  = 450,
    parameter int SURFACE_Y  = 155,
    parameter int REEL_Y     = 105,
    parameter int LANE_Y0    = 470,
    parameter int LANE_STEP  = 90,
    parameter int FISH_SPEED = 2,
    parameter int LINE_DROP  = 4,
    parameter int REEL_SPEED = 2,
    parameter int ROD_SPEED  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [9:0] rod_x,
    output logic [9:0] line_y,
    output logic [9:0] fish_x,
    output logic [9:0] fish_y,
    output logic [5:0] fish_half_h,
    output logic [6:0] fish_len,
    output logic       fish_visible,
    output logic [2:0] level,
    output logic [1:0] state,
    output logic       won,
    output logic       catch_pulse
);

    if (NUM_LEVELS < 2 || NUM_LEVELS > 8) begin : g_chk_lv
        $error("fish_game_ctrl: NUM_LEVELS must be 2..8");
    end
    if (LANE_Y0 - (NUM_LEVELS - 1) * LANE_STEP
        <= REEL_Y + 16) begin : g_chk_lane
        $error("fish_game_ctrl: top lane too close to REEL_Y");
    end

    localparam logic [9:0] HMIN    = 10'(H_MIN);
    localparam logic [9:0] HMAX    = 10'(H_MAX);
    localparam logic [9:0] ROD_RST = 10'(ROD_X_RST);
    localparam logic [9:0] SURF    = 10'(SURFACE_Y);
    localparam logic [9:0] REELY   = 10'(REEL_Y);
    localparam logic [9:0] LANE0   = 10'(LANE_Y0);
    localparam logic [9:0] FSPD    = 10'(FISH_SPEED);
    localparam logic [9:0] LDROP   = 10'(LINE_DROP);
    localparam logic [9:0] RSPD    = 10'(REEL_SPEED);
    localparam logic [9:0] ROD_SPD = 10'(ROD_SPEED);
    localparam logic [9:0] FX_WRAP = 10'(H_MIN + FISH_SPEED);
    localparam logic [9:0] REEL_LO = 10'(REEL_Y + REEL_SPEED);
    localparam logic [9:0] ROD_HI  = 10'(H_MAX - ROD_SPEED);
    localparam logic [9:0] ROD_LO  = 10'(H_MIN + ROD_SPEED);
    localparam logic [2:0] LAST_LV = 3'(NUM_LEVELS - 1);

    game_state_e state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic [9:0]  rod_x_q, rod_x_d;
    logic [9:0]  line_y_q, line_y_d;
    logic [9:0]  fish_x_q, fish_x_d;
    logic [9:0]  fish_y_q, fish_y_d;
    logic        catch_q, catch_d;

    level_geom_t geom;
    logic [9:0]  next_lane;

    fish_level_rom #(
        .NUM_LEVELS (NUM_LEVELS),
        .LANE_Y0    (LANE_Y0),
        .LANE_STEP  (LANE_STEP)
    ) u_rom (
        .level       (level_q),
        .geom        (geom),
        .next_lane_y (next_lane)
    );

    logic [9:0] dy;
    logic [9:0] fx_step;
    logic [9:0] ly_drop;
    logic [9:0] rod_step;
    logic [9:0] fy_reel;
    logic [9:0] ly_reel;
    logic       hook;
    logic       reel_done;
    logic       legal;
    logic       restart;

    assign dy = (line_y_q >= fish_y_q)
              ? line_y_q - fish_y_q
              : fish_y_q - line_y_q;

    assign hook = up
               && (rod_x_q >= fish_x_q)
               && (rod_x_q <= fish_x_q + {3'b0, geom.hook_w})
               && (dy <= {4'b0, geom.half_h});

    assign fx_step = (fish_x_q <= FX_WRAP)
                   ? HMAX : fish_x_q - FSPD;

    assign ly_drop = (line_y_q + LDROP >= geom.lane_y)
                   ? geom.lane_y : line_y_q + LDROP;

    always_comb begin
        rod_step = rod_x_q;
        if (right)
            rod_step = (rod_x_q >= ROD_HI)
                     ? HMAX : rod_x_q + ROD_SPD;
        else if (left)
            rod_step = (rod_x_q <= ROD_LO)
                     ? HMIN : rod_x_q - ROD_SPD;
    end

    // Catch completes on the tick that would lift the fish to REEL_Y.
    assign reel_done = fish_y_q <= REEL_LO;
    assign fy_reel   = fish_y_q - RSPD;
    assign ly_reel   = (line_y_q <= REEL_LO)
                     ? REELY : line_y_q - RSPD;

    assign legal = (state_q inside {ST_FISH, ST_CATCH, ST_WIN})
                && (level_q <= LAST_LV);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FISH;
            level_q  <= 3'd0;
            rod_x_q  <= ROD_RST;
            line_y_q <= SURF;
            fish_x_q <= HMAX;
            fish_y_q <= LANE0;
            catch_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            rod_x_q  <= rod_x_d;
            line_y_q <= line_y_d;
            fish_x_q <= fish_x_d;
            fish_y_q <= fish_y_d;
            catch_q  <= catch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        rod_x_d  = rod_x_q;
        line_y_d = line_y_q;
        fish_x_d = fish_x_q;
        fish_y_d = fish_y_q;
        catch_d  = 1'b0;
        restart  = 1'b0;
        if (!legal) begin
            restart = 1'b1;
        end else if (tick) begin
            unique case (state_q)
                ST_FISH: begin
                    // A hook freezes the scene where line met fish.
                    if (hook) begin
                        state_d = ST_CATCH;
                        catch_d = 1'b1;
                    end else begin
                        fish_x_d = fx_step;
                        line_y_d = ly_drop;
                        rod_x_d  = rod_step;
                    end
                end
                ST_CATCH: begin
                    if (up && reel_done) begin
                        if (level_q == LAST_LV) begin
                            state_d = ST_WIN;
                        end else begin
                            state_d  = ST_FISH;
                            level_d  = level_q + 3'd1;
                            fish_x_d = HMAX;
                            fish_y_d = next_lane;
                            line_y_d = SURF;
                        end
                    end else if (up) begin
                        fish_y_d = fy_reel;
                        line_y_d = ly_reel;
                    end else if (down) begin
                        state_d  = ST_FISH;
                        fish_x_d = HMAX;
                        fish_y_d = geom.lane_y;
                        line_y_d = SURF;
                    end
                end
                ST_WIN: begin
                    restart = up | down | left | right;
                end
                default: begin
                    restart = 1'b1;
                end
            endcase
        end
        if (restart) begin
            state_d  = ST_FISH;
            level_d  = 3'd0;
            rod_x_d  = ROD_RST;
            line_y_d = SURF;
            fish_x_d = HMAX;
            fish_y_d = LANE0;
            catch_d  = 1'b0;
        end
    end

    always_comb begin
        state        = state_q;
        level        = level_q;
        rod_x        = rod_x_q;
        line_y       = line_y_q;
        fish_x       = fish_x_q;
        fish_y       = fish_y_q;
        fish_half_h  = geom.half_h;
        fish_len     = geom.len;
        catch_pulse  = catch_q;
        won          = (state_q == ST_WIN);
        fish_visible = (state_q != ST_WIN);
    end

endmodule
